// File: rtl/mio_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mio_bus_arbiter
// Shares one synchronous memory/MIO port between the multi-cycle CPU (port A)
// and a secondary master such as a DMA or debug loader (port B). A winning
// request is latched in IDLE, driven onto the memory port for WAIT_CYCLES+1
// ACCESS cycles, and completed by a one-cycle ready pulse in RESP. One IDLE
// cycle always separates two transactions.
//
// Parameters:
//   ADDR_W        address width of all ports
//   DATA_W        data width of all ports
//   WAIT_CYCLES   extra memory wait cycles per access (0..15)
//   CPU_PRIORITY  1 = CPU wins every tie, 0 = round-robin between masters
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   cpu_req/we/addr/wdata       CPU request, held until cpu_ready
//   cpu_rdata, cpu_ready        CPU read data and completion pulse
//   dma_req/we/addr/wdata       secondary-master request
//   dma_rdata, dma_ready        secondary-master read data and completion pulse
//   mem_en/we/addr/wdata        shared memory port (all registered)
//   mem_rdata                   memory read data, valid by end of last ACCESS
//   grant                       one-hot owner: [0] CPU, [1] secondary
//   busy                        high whenever the arbiter is not IDLE
// -----------------------------------------------------------------------------
module mio_bus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int WAIT_CYCLES  = 1,
    parameter int CPU_PRIORITY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Terminal value of the wait counter; ACCESS lasts LP_LAST_WAIT+1 cycles.
    localparam logic [3:0] LP_LAST_WAIT = 4'(WAIT_CYCLES);

    state_t            r_state;
    logic [3:0]        r_waitCnt;
    logic              r_lastGrantDma;
    logic              r_isWrite;
    logic [1:0]        r_grant;
    logic              r_busy;
    logic              r_cpuReady;
    logic              r_dmaReady;
    logic              r_memEn;
    logic              r_memWe;
    logic [ADDR_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memWdata;
    logic [DATA_W-1:0] r_cpuRdata;
    logic [DATA_W-1:0] r_dmaRdata;

    logic              w_anyReq;
    logic              w_pickDma;
    logic              w_winWe;
    logic [ADDR_W-1:0] w_winAddr;
    logic [DATA_W-1:0] w_winWdata;

    // Winner selection. On a tie, round-robin favours whichever master did
    // not win last time; r_lastGrantDma resets high so the CPU wins the
    // first tie after reset.
    always_comb begin
        w_anyReq = cpu_req | dma_req;
        if (cpu_req && dma_req) begin
            w_pickDma = (CPU_PRIORITY != 0) ? 1'b0 : ~r_lastGrantDma;
        end else begin
            w_pickDma = dma_req;
        end
        w_winWe    = w_pickDma ? dma_we    : cpu_we;
        w_winAddr  = w_pickDma ? dma_addr  : cpu_addr;
        w_winWdata = w_pickDma ? dma_wdata : cpu_wdata;
    end

    // Arbiter FSM with all outputs registered. The memory address and write
    // data registers double as the transaction latch, so later changes on
    // the master's inputs cannot disturb an access in flight. Reset in any
    // state aborts the transaction and clears both read-data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_waitCnt      <= 4'd0;
            r_lastGrantDma <= 1'b1;
            r_isWrite      <= 1'b0;
            r_grant        <= 2'b00;
            r_busy         <= 1'b0;
            r_cpuReady     <= 1'b0;
            r_dmaReady     <= 1'b0;
            r_memEn        <= 1'b0;
            r_memWe        <= 1'b0;
            r_memAddr      <= '0;
            r_memWdata     <= '0;
            r_cpuRdata     <= '0;
            r_dmaRdata     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_anyReq) begin
                        r_state        <= ST_ACCESS;
                        r_waitCnt      <= 4'd0;
                        r_lastGrantDma <= w_pickDma;
                        r_grant        <= w_pickDma ? 2'b10 : 2'b01;
                        r_busy         <= 1'b1;
                        r_isWrite      <= w_winWe;
                        r_memEn        <= 1'b1;
                        r_memWe        <= w_winWe;
                        r_memAddr      <= w_winAddr;
                        r_memWdata     <= w_winWdata;
                    end
                end
                ST_ACCESS: begin
                    // Write strobe is confined to the first ACCESS cycle.
                    r_memWe <= 1'b0;
                    if (r_waitCnt == LP_LAST_WAIT) begin
                        r_state <= ST_RESP;
                        r_memEn <= 1'b0;
                        if (r_grant[0]) begin
                            r_cpuReady <= 1'b1;
                            if (!r_isWrite) begin
                                r_cpuRdata <= mem_rdata;
                            end
                        end else begin
                            r_dmaReady <= 1'b1;
                            if (!r_isWrite) begin
                                r_dmaRdata <= mem_rdata;
                            end
                        end
                    end else begin
                        r_waitCnt <= r_waitCnt + 4'd1;
                    end
                end
                ST_RESP: begin
                    r_state    <= ST_IDLE;
                    r_cpuReady <= 1'b0;
                    r_dmaReady <= 1'b0;
                    r_grant    <= 2'b00;
                    r_busy     <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata = r_cpuRdata;
    assign cpu_ready = r_cpuReady;
    assign dma_rdata = r_dmaRdata;
    assign dma_ready = r_dmaReady;
    assign mem_en    = r_memEn;
    assign mem_we    = r_memWe;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign grant     = r_grant;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mio_bus_arbiter
// Two arbiter instances run side by side: instance 0 with one wait cycle and
// round-robin arbitration, instance 1 with zero wait cycles and fixed CPU
// priority. Each instance has a small memory behind its port. Directed
// scenarios cover the documented timelines; a randomized scenario compares
// against a transaction-level model that schedules grants arithmetically.
// -----------------------------------------------------------------------------
module tb_mio_bus_arbiter;

    localparam int W0 = 1;
    localparam int W1 = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpuReq [2];
    logic        cpuWe [2];
    logic [31:0] cpuAddr [2];
    logic [31:0] cpuWdata [2];
    logic [31:0] cpuRdata [2];
    logic        cpuReady [2];
    logic        dmaReq [2];
    logic        dmaWe [2];
    logic [31:0] dmaAddr [2];
    logic [31:0] dmaWdata [2];
    logic [31:0] dmaRdata [2];
    logic        dmaReady [2];
    logic        memEn [2];
    logic        memWe [2];
    logic [31:0] memAddr [2];
    logic [31:0] memWdata [2];
    logic [31:0] memRdata [2];
    logic [1:0]  grant [2];
    logic        busy [2];

    logic [31:0] refMem [2][256];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    // Power-on memory contents; word 0x10 holds a recognisable read value.
    function automatic logic [31:0] memInit(input int g, input int i);
        if (i == 16) return 32'hDEADBEEF;
        return 32'h5A00_0000 ^ 32'(g << 16) ^ 32'(i * 32'h0001_0203);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        logic [31:0] memArr [256];

        mio_bus_arbiter #(
            .ADDR_W      (32),
            .DATA_W      (32),
            .WAIT_CYCLES ((g == 0) ? W0 : W1),
            .CPU_PRIORITY((g == 0) ? 0 : 1)
        ) dut (
            .clk      (clk),
            .reset    (reset),
            .cpu_req  (cpuReq[g]),
            .cpu_we   (cpuWe[g]),
            .cpu_addr (cpuAddr[g]),
            .cpu_wdata(cpuWdata[g]),
            .cpu_rdata(cpuRdata[g]),
            .cpu_ready(cpuReady[g]),
            .dma_req  (dmaReq[g]),
            .dma_we   (dmaWe[g]),
            .dma_addr (dmaAddr[g]),
            .dma_wdata(dmaWdata[g]),
            .dma_rdata(dmaRdata[g]),
            .dma_ready(dmaReady[g]),
            .mem_en   (memEn[g]),
            .mem_we   (memWe[g]),
            .mem_addr (memAddr[g]),
            .mem_wdata(memWdata[g]),
            .mem_rdata(memRdata[g]),
            .grant    (grant[g]),
            .busy     (busy[g])
        );

        // Word-indexed memory on the low address byte; reloaded during reset.
        always @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < 256; i++) memArr[i] <= memInit(g, i);
            end else if (memEn[g] && memWe[g]) begin
                memArr[memAddr[g][7:0]] <= memWdata[g];
            end
        end

        assign memRdata[g] = memArr[memAddr[g][7:0]];
    end

    // Drive every request input idle.
    task automatic clearInputs();
        for (int g = 0; g < 2; g++) begin
            cpuReq[g] = 1'b0; cpuWe[g] = 1'b0; cpuAddr[g] = '0; cpuWdata[g] = '0;
            dmaReq[g] = 1'b0; dmaWe[g] = 1'b0; dmaAddr[g] = '0; dmaWdata[g] = '0;
        end
    endtask

    // Two reset cycles, then release; the model memory is reloaded to match.
    task automatic applyReset();
        reset = 1'b1;
        clearInputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < 256; i++) refMem[g][i] = memInit(g, i);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int g = 0; g < 2; g++) begin
            cpuReq[g] = 1'b1; cpuWe[g] = 1'b1; cpuAddr[g] = $urandom; cpuWdata[g] = $urandom;
            dmaReq[g] = 1'b1; dmaWe[g] = 1'b1; dmaAddr[g] = $urandom; dmaWdata[g] = $urandom;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            vectors++;
            if ({grant[g], busy[g], cpuReady[g], dmaReady[g], memEn[g], memWe[g]} !== 7'b0) begin
                miscompares++;
                $display("FAIL reset_ctrl inst=%0d got=%b exp=0000000", g,
                         {grant[g], busy[g], cpuReady[g], dmaReady[g], memEn[g], memWe[g]});
            end
            vectors++;
            if ({memAddr[g], memWdata[g]} !== 64'b0) begin
                miscompares++;
                $display("FAIL reset_membus inst=%0d got=%h/%h exp=0/0", g, memAddr[g], memWdata[g]);
            end
            vectors++;
            if ({cpuRdata[g], dmaRdata[g]} !== 64'b0) begin
                miscompares++;
                $display("FAIL reset_rdata inst=%0d got=%h/%h exp=0/0", g, cpuRdata[g], dmaRdata[g]);
            end
        end
        applyReset();
    endtask

    // Instance 0: CPU read of 0x10, request sampled at the end of cycle 0.
    task automatic test_cpu_read();
        logic [1:0] eG;
        logic       eEn;
        logic       eRdy;
        applyReset();
        for (int j = 0; j < 6; j++) begin
            eG   = (j >= 1 && j <= 3) ? 2'b01 : 2'b00;
            eEn  = (j == 1 || j == 2);
            eRdy = (j == 3);
            vectors++;
            if (grant[0] !== eG) begin
                miscompares++;
                $display("FAIL rd_grant cyc=%0d got=%b exp=%b", j, grant[0], eG);
            end
            vectors++;
            if ({memEn[0], memWe[0]} !== {eEn, 1'b0}) begin
                miscompares++;
                $display("FAIL rd_mem_en_we cyc=%0d got=%b exp=%b", j, {memEn[0], memWe[0]}, {eEn, 1'b0});
            end
            vectors++;
            if ({cpuReady[0], dmaReady[0]} !== {eRdy, 1'b0}) begin
                miscompares++;
                $display("FAIL rd_ready cyc=%0d got=%b exp=%b", j, {cpuReady[0], dmaReady[0]}, {eRdy, 1'b0});
            end
            if (eEn) begin
                vectors++;
                if (memAddr[0] !== 32'h0000_0010) begin
                    miscompares++;
                    $display("FAIL rd_mem_addr cyc=%0d got=%h exp=00000010", j, memAddr[0]);
                end
            end
            if (eRdy) begin
                vectors++;
                if (cpuRdata[0] !== 32'hDEADBEEF) begin
                    miscompares++;
                    $display("FAIL rd_data got=%h exp=deadbeef", cpuRdata[0]);
                end
            end
            if (j == 0) begin
                cpuReq[0] = 1'b1; cpuWe[0] = 1'b0; cpuAddr[0] = 32'h10; cpuWdata[0] = 32'hFFFF_0000;
            end
            if (j == 1) cpuAddr[0] = 32'h44;
            if (j == 3) cpuReq[0] = 1'b0;
            @(negedge clk);
        end
    endtask

    // Instance 0: CPU write of 0x12345678 to 0x20, then a read back.
    // Follows test_cpu_read without reset, so cpu_rdata still holds 0xDEADBEEF.
    task automatic test_cpu_write();
        logic eWe;
        for (int j = 0; j < 6; j++) begin
            eWe = (j == 1);
            vectors++;
            if (memWe[0] !== eWe) begin
                miscompares++;
                $display("FAIL wr_strobe cyc=%0d got=%b exp=%b", j, memWe[0], eWe);
            end
            if (eWe) begin
                vectors++;
                if ({memAddr[0], memWdata[0]} !== {32'h20, 32'h1234_5678}) begin
                    miscompares++;
                    $display("FAIL wr_bus got=%h/%h exp=00000020/12345678", memAddr[0], memWdata[0]);
                end
            end
            vectors++;
            if ({cpuReady[0], dmaReady[0]} !== {(j == 3), 1'b0}) begin
                miscompares++;
                $display("FAIL wr_ready cyc=%0d got=%b exp=%b", j, {cpuReady[0], dmaReady[0]}, {(j == 3), 1'b0});
            end
            vectors++;
            if (cpuRdata[0] !== 32'hDEADBEEF) begin
                miscompares++;
                $display("FAIL wr_rdata_kept cyc=%0d got=%h exp=deadbeef", j, cpuRdata[0]);
            end
            if (j == 0) begin
                cpuReq[0] = 1'b1; cpuWe[0] = 1'b1; cpuAddr[0] = 32'h20; cpuWdata[0] = 32'h1234_5678;
            end
            if (j == 2) cpuWdata[0] = 32'h0BAD_0BAD;
            if (j == 3) begin
                cpuReq[0] = 1'b0; cpuWe[0] = 1'b0;
            end
            @(negedge clk);
        end
        cpuReq[0] = 1'b1; cpuWe[0] = 1'b0; cpuAddr[0] = 32'h20;
        for (int j = 0; j < 5; j++) begin
            if (j == 3) begin
                vectors++;
                if ({cpuReady[0], cpuRdata[0]} !== {1'b1, 32'h1234_5678}) begin
                    miscompares++;
                    $display("FAIL wr_readback got=%b/%h exp=1/12345678", cpuReady[0], cpuRdata[0]);
                end
                cpuReq[0] = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    // Instance 0: both masters hold read requests from reset; grants
    // alternate CPU, DMA, ... with one transaction every W0+3 cycles.
    task automatic test_round_robin();
        int         n;
        int         rdyIdx;
        logic [1:0] eG;
        logic       eC;
        logic       eD;
        applyReset();
        for (int j = 0; j < 20; j++) begin
            n      = (j - 1) / (W0 + 3);
            eG     = (j >= 1 && ((j - 1) % (W0 + 3)) <= W0 + 1) ? ((n % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            rdyIdx = (j >= W0 + 2 && ((j - W0 - 2) % (W0 + 3)) == 0) ? (j - W0 - 2) / (W0 + 3) : -1;
            eC     = (rdyIdx >= 0) && (rdyIdx % 2 == 0);
            eD     = (rdyIdx >= 0) && (rdyIdx % 2 == 1);
            vectors++;
            if (grant[0] !== eG) begin
                miscompares++;
                $display("FAIL rr_grant cyc=%0d got=%b exp=%b", j, grant[0], eG);
            end
            vectors++;
            if ({cpuReady[0], dmaReady[0]} !== {eC, eD}) begin
                miscompares++;
                $display("FAIL rr_ready cyc=%0d got=%b exp=%b", j, {cpuReady[0], dmaReady[0]}, {eC, eD});
            end
            if (eC) begin
                vectors++;
                if (cpuRdata[0] !== memInit(0, 8'h30)) begin
                    miscompares++;
                    $display("FAIL rr_cpu_rdata got=%h exp=%h", cpuRdata[0], memInit(0, 8'h30));
                end
            end
            if (eD) begin
                vectors++;
                if (dmaRdata[0] !== memInit(0, 8'h34)) begin
                    miscompares++;
                    $display("FAIL rr_dma_rdata got=%h exp=%h", dmaRdata[0], memInit(0, 8'h34));
                end
            end
            if (j == 0) begin
                cpuReq[0] = 1'b1; cpuAddr[0] = 32'h30;
                dmaReq[0] = 1'b1; dmaAddr[0] = 32'h34;
            end
            if (j == 19) begin
                cpuReq[0] = 1'b0; dmaReq[0] = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    // Instance 1 (no wait cycles, CPU priority): the CPU keeps winning until
    // it drops its request, then the DMA is served after one IDLE cycle.
    task automatic test_priority();
        logic [1:0] eG;
        logic       eC;
        logic       eD;
        applyReset();
        for (int j = 0; j < 17; j++) begin
            if (j >= 1 && j <= 11 && ((j - 1) % 3) != 2) eG = 2'b01;
            else if (j == 13 || j == 14)                 eG = 2'b10;
            else                                         eG = 2'b00;
            eC = (j == 2 || j == 5 || j == 8 || j == 11);
            eD = (j == 14);
            vectors++;
            if (grant[1] !== eG) begin
                miscompares++;
                $display("FAIL prio_grant cyc=%0d got=%b exp=%b", j, grant[1], eG);
            end
            vectors++;
            if ({cpuReady[1], dmaReady[1]} !== {eC, eD}) begin
                miscompares++;
                $display("FAIL prio_ready cyc=%0d got=%b exp=%b", j, {cpuReady[1], dmaReady[1]}, {eC, eD});
            end
            if (eD) begin
                vectors++;
                if (dmaRdata[1] !== memInit(1, 8'h70)) begin
                    miscompares++;
                    $display("FAIL prio_dma_rdata got=%h exp=%h", dmaRdata[1], memInit(1, 8'h70));
                end
            end
            if (j == 0) begin
                cpuReq[1] = 1'b1; cpuAddr[1] = 32'h60;
                dmaReq[1] = 1'b1; dmaAddr[1] = 32'h70;
            end
            if (j == 11) cpuReq[1] = 1'b0;
            if (j == 14) dmaReq[1] = 1'b0;
            @(negedge clk);
        end
    endtask

    // Instance 1: single DMA read with zero wait cycles.
    task automatic test_zero_wait();
        applyReset();
        for (int j = 0; j < 5; j++) begin
            vectors++;
            if ({memEn[1], busy[1], grant[1]} !== {(j == 1), (j == 1 || j == 2), (j == 1 || j == 2) ? 2'b10 : 2'b00}) begin
                miscompares++;
                $display("FAIL zw_en_busy_grant cyc=%0d got=%b", j, {memEn[1], busy[1], grant[1]});
            end
            vectors++;
            if ({cpuReady[1], dmaReady[1]} !== {1'b0, (j == 2)}) begin
                miscompares++;
                $display("FAIL zw_ready cyc=%0d got=%b exp=%b", j, {cpuReady[1], dmaReady[1]}, {1'b0, (j == 2)});
            end
            if (j == 2) begin
                vectors++;
                if (dmaRdata[1] !== memInit(1, 8'h58)) begin
                    miscompares++;
                    $display("FAIL zw_rdata got=%h exp=%h", dmaRdata[1], memInit(1, 8'h58));
                end
                dmaReq[1] = 1'b0;
            end
            if (j == 0) begin
                dmaReq[1] = 1'b1; dmaWe[1] = 1'b0; dmaAddr[1] = 32'h58;
            end
            @(negedge clk);
        end
    endtask

    // Instance 0: a completed DMA read, then a second one aborted by reset in
    // its second ACCESS cycle; no ready pulse follows and dma_rdata clears.
    task automatic test_reset_abort();
        logic [31:0] eRd;
        logic        eBusy;
        applyReset();
        for (int j = 0; j < 9; j++) begin
            eBusy = (j >= 1 && j <= 3) || (j == 5 || j == 6);
            eRd   = (j >= 3 && j <= 6) ? memInit(0, 8'h64) : 32'h0;
            vectors++;
            if ({busy[0], memEn[0]} !== {eBusy, eBusy && j != 3}) begin
                miscompares++;
                $display("FAIL abort_busy_en cyc=%0d got=%b exp=%b", j, {busy[0], memEn[0]}, {eBusy, eBusy && j != 3});
            end
            vectors++;
            if ({dmaReady[0], cpuReady[0]} !== {(j == 3), 1'b0}) begin
                miscompares++;
                $display("FAIL abort_ready cyc=%0d got=%b exp=%b", j, {dmaReady[0], cpuReady[0]}, {(j == 3), 1'b0});
            end
            vectors++;
            if (dmaRdata[0] !== eRd) begin
                miscompares++;
                $display("FAIL abort_rdata cyc=%0d got=%h exp=%h", j, dmaRdata[0], eRd);
            end
            if (j == 0) begin
                dmaReq[0] = 1'b1; dmaAddr[0] = 32'h64;
            end
            if (j == 3) dmaReq[0] = 1'b0;
            if (j == 4) begin
                dmaReq[0] = 1'b1; dmaAddr[0] = 32'h68;
            end
            if (j == 6) reset = 1'b1;
            if (j == 7) begin
                reset = 1'b0; dmaReq[0] = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    // Random traffic on one instance. The model keeps one transaction record
    // and derives the whole bus timeline from its decision cycle k: ACCESS in
    // k+1..k+W+1, ready in k+W+2, next decision in k+W+3.
    task automatic test_random(input int idx, input int nCycles);
        int          w;
        int          decideAt;
        int          txnStart;
        int          txnWin;
        int          lastDma;
        logic        txnWe;
        logic [31:0] txnAddr;
        logic [31:0] txnWdata;
        logic [31:0] rdVal;
        logic [31:0] tmp;
        logic        act [2];
        logic        inSvc [2];
        logic        mWe [2];
        logic [31:0] mAddr [2];
        logic [31:0] mWdata [2];
        logic [31:0] expRd [2];
        logic        inWin;
        logic        eEn;
        logic        eWe;
        logic        rdy;
        logic [1:0]  eG;

        w = (idx == 0) ? W0 : W1;
        applyReset();
        decideAt = 0; txnStart = -100; txnWin = -1; lastDma = 1;
        txnWe = 1'b0; txnAddr = '0; txnWdata = '0; rdVal = '0;
        for (int m = 0; m < 2; m++) begin
            act[m] = 1'b0; inSvc[m] = 1'b0; mWe[m] = 1'b0;
            mAddr[m] = '0; mWdata[m] = '0; expRd[m] = '0;
        end

        for (int k = 0; k < nCycles + 24; k++) begin
            inWin = (txnWin >= 0) && (k > txnStart) && (k <= txnStart + w + 2);
            eEn   = (txnWin >= 0) && (k > txnStart) && (k <= txnStart + w + 1);
            eWe   = (txnWin >= 0) && txnWe && (k == txnStart + 1);
            rdy   = (txnWin >= 0) && (k == txnStart + w + 2);
            eG    = !inWin ? 2'b00 : ((txnWin == 1) ? 2'b10 : 2'b01);
            if (rdy && !txnWe) expRd[txnWin] = rdVal;

            vectors++;
            if ({grant[idx], busy[idx], memEn[idx], memWe[idx]} !== {eG, inWin, eEn, eWe}) begin
                miscompares++;
                $display("FAIL rnd_ctrl inst=%0d cyc=%0d got=%b exp=%b", idx, k,
                         {grant[idx], busy[idx], memEn[idx], memWe[idx]}, {eG, inWin, eEn, eWe});
            end
            vectors++;
            if ({cpuReady[idx], dmaReady[idx]} !== {rdy && txnWin == 0, rdy && txnWin == 1}) begin
                miscompares++;
                $display("FAIL rnd_ready inst=%0d cyc=%0d got=%b exp=%b", idx, k,
                         {cpuReady[idx], dmaReady[idx]}, {rdy && txnWin == 0, rdy && txnWin == 1});
            end
            vectors++;
            if ({cpuRdata[idx], dmaRdata[idx]} !== {expRd[0], expRd[1]}) begin
                miscompares++;
                $display("FAIL rnd_rdata inst=%0d cyc=%0d got=%h/%h exp=%h/%h", idx, k,
                         cpuRdata[idx], dmaRdata[idx], expRd[0], expRd[1]);
            end
            if (eEn) begin
                vectors++;
                if ({memAddr[idx], memWdata[idx]} !== {txnAddr, txnWdata}) begin
                    miscompares++;
                    $display("FAIL rnd_membus inst=%0d cyc=%0d got=%h/%h exp=%h/%h", idx, k,
                             memAddr[idx], memWdata[idx], txnAddr, txnWdata);
                end
            end

            if (rdy) begin
                act[txnWin] = 1'b0; inSvc[txnWin] = 1'b0;
            end
            for (int m = 0; m < 2; m++) begin
                if (!act[m] && k < nCycles && $urandom_range(0, 2) == 0) begin
                    act[m]    = 1'b1;
                    mWe[m]    = 1'($urandom_range(0, 1));
                    tmp       = $urandom;
                    mAddr[m]  = (tmp & 32'hFFFF_FF00) | (32'($urandom_range(0, 15)) << 2);
                    mWdata[m] = $urandom;
                end
            end
            // Once granted, a master's fields are scrambled; the access must not notice.
            cpuReq[idx]   = act[0];
            cpuWe[idx]    = inSvc[0] ? 1'($urandom_range(0, 1)) : mWe[0];
            cpuAddr[idx]  = inSvc[0] ? 32'($urandom) : mAddr[0];
            cpuWdata[idx] = inSvc[0] ? 32'($urandom) : mWdata[0];
            dmaReq[idx]   = act[1];
            dmaWe[idx]    = inSvc[1] ? 1'($urandom_range(0, 1)) : mWe[1];
            dmaAddr[idx]  = inSvc[1] ? 32'($urandom) : mAddr[1];
            dmaWdata[idx] = inSvc[1] ? 32'($urandom) : mWdata[1];

            if (k == decideAt) begin
                if (act[0] || act[1]) begin
                    if (act[0] && act[1]) txnWin = (idx == 1) ? 0 : ((lastDma != 0) ? 0 : 1);
                    else                  txnWin = act[1] ? 1 : 0;
                    lastDma  = txnWin;
                    txnStart = k;
                    txnWe    = mWe[txnWin];
                    txnAddr  = mAddr[txnWin];
                    txnWdata = mWdata[txnWin];
                    rdVal    = refMem[idx][txnAddr[7:0]];
                    if (txnWe) refMem[idx][txnAddr[7:0]] = txnWdata;
                    inSvc[txnWin] = 1'b1;
                    decideAt = k + w + 3;
                end else begin
                    decideAt = k + 1;
                end
            end
            @(negedge clk);
        end
        clearInputs();
    endtask

    initial begin
        reset = 1'b1;
        clearInputs();
        applyReset();
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_round_robin();
        test_priority();
        test_zero_wait();
        test_reset_abort();
        test_random(0, 400);
        test_random(1, 400);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mio_bus_arbiter.md
Name: mio_bus_arbiter

Overview:
Shares one synchronous memory/MIO port between two bus masters: the multi-cycle CPU (port A) and a secondary master such as a DMA or debug loader (port B). Arbitrates requests, latches the winning transaction, drives the memory port for a fixed number of wait cycles, then returns read data with a one-cycle ready pulse. The CPU-facing ready output feeds the CPU's MIO_ready input directly. The CPU's CPU_MIO, mem_w, Addr_out and Data_out outputs drive cpu_req, cpu_we, cpu_addr and cpu_wdata.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
WAIT_CYCLES, 1, extra memory wait cycles per access; legal range 0..15
CPU_PRIORITY, 0, 1 = CPU always wins ties (fixed priority); 0 = round-robin

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU transaction request, level; held until cpu_ready
cpu_we  in  1  CPU write enable (1 = write, 0 = read)
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  CPU read data, valid when cpu_ready
cpu_ready  out  1  one-cycle completion pulse to CPU
dma_req  in  1  secondary-master request, level
dma_we  in  1  secondary-master write enable
dma_addr  in  ADDR_W  secondary-master address
dma_wdata  in  DATA_W  secondary-master write data
dma_rdata  out  DATA_W  secondary-master read data
dma_ready  out  1  one-cycle completion pulse to secondary master
mem_en  out  1  memory port enable
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid by end of last ACCESS cycle
grant  out  2  one-hot owner: [0] CPU, [1] secondary; 0 when IDLE
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, active-high) values: state IDLE, wait counter 0, grant 0, busy 0, cpu_ready 0, dma_ready 0, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_rdata 0, dma_rdata 0. The last-grant register resets to "secondary", so the CPU wins the first tie.
- States: IDLE, ACCESS, RESP.
- IDLE: if no request, stay. If any request, pick a winner and latch its we/addr/wdata into internal registers. Set grant, clear the counter, go to ACCESS.
- Arbitration when both request:
  - CPU_PRIORITY=1: CPU wins.
  - CPU_PRIORITY=0: the master not granted last time wins.
  - A single requester always wins. last_grant updates on every grant.
- ACCESS: lasts exactly WAIT_CYCLES+1 cycles.
  - mem_en=1 throughout; mem_addr and mem_wdata come from the latched registers and stay stable.
  - mem_we=1 only in the first ACCESS cycle of a write, so there is exactly one write strobe per transaction.
  - The counter increments each cycle. When counter==WAIT_CYCLES, go to RESP and capture mem_rdata on that edge if the transaction is a read.
- RESP: one cycle. mem_en=0. The granted master's ready=1. Its rdata register shows the captured data (reads) or is unchanged (writes). The other master's rdata is never modified. Next state is IDLE.
- Latency: request sampled in IDLE at cycle N; ready high in cycle N+WAIT_CYCLES+2.
- Bus turnaround: one mandatory IDLE cycle after RESP. A master must drop or update its request on the edge ending its ready cycle, which prevents double service. Back-to-back transactions from one master therefore have a period of WAIT_CYCLES+3 cycles.
- Request inputs are ignored outside IDLE. Changes to a master's addr/wdata after grant have no effect on the in-flight access.
- At most one ready output is high in any cycle. Ready is never high outside RESP.
- Reset asserted mid-ACCESS or in RESP: return to IDLE on that edge. The transaction is aborted, no ready pulse is issued, and rdata registers are cleared.
- Counter width is 4 bits and never wraps, since terminal count ≤ 15.

Test Plan:
- WAIT_CYCLES=1, CPU read at 0x0000_0010 with mem returning 0xDEADBEEF, req at cycle 0 → mem_en high cycles 1–2, cpu_ready high cycle 3 only, cpu_rdata=0xDEADBEEF, grant=01 cycles 1–3.
- CPU write 0x12345678 to 0x20 → mem_we high exactly one cycle with mem_addr=0x20 and mem_wdata=0x12345678; cpu_rdata unchanged; dma_ready never high.
- CPU_PRIORITY=0, both requests held continuously from reset → grants alternate CPU, DMA, CPU, DMA; each ready pulse spaced WAIT_CYCLES+3 cycles apart.
- CPU_PRIORITY=1, both requests held → CPU granted every transaction; DMA granted only after cpu_req drops, within one IDLE cycle.
- DMA read in flight, reset asserted in its second ACCESS cycle → next cycle IDLE, mem_en=0, no dma_ready pulse, dma_rdata=0, busy=0.
- WAIT_CYCLES=0, single DMA read → ACCESS lasts one cycle, dma_ready two cycles after the request is sampled.
